// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared types and helpers for the pipeline hazard scoreboard:
//               forward-select encoding, shadow tag layout, hit detection.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] dest;
        logic       ld;
    } tag_t;

    localparam int unsigned C_NUM_GPR = 32;
    localparam logic [1:0]  C_CNT_MAX = 2'd3;

    function automatic logic tag_hit(input tag_t t, input logic re, input logic [4:0] addr);
        return re && (addr != 5'd0) && t.v && t.we && (t.dest == addr);
    endfunction

    // Youngest in-flight producer wins.
    function automatic fwd_sel_e fwd_select(input logic re, input logic [4:0] addr,
                                            input tag_t e, input tag_t m, input tag_t w);
        if (tag_hit(e, re, addr))      return FWD_EXE;
        else if (tag_hit(m, re, addr)) return FWD_MEM;
        else if (tag_hit(w, re, addr)) return FWD_WB;
        else                           return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : Pipeline-side bundle between the core control and the
//               hazard scoreboard (ID operands, stage fires, hazard results).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if;

    logic        id_valid;
    logic [4:0]  id_raddr1;
    logic [4:0]  id_raddr2;
    logic        id_re1;
    logic        id_re2;
    logic        ds_fire;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;
    logic        ds_is_load;
    logic        es_fire;
    logic        ms_fire;
    logic        ws_fire;
    logic        block_id;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic [31:0] sb_busy;
    logic [31:0] stall_cnt;
    logic        sb_overflow;

    modport master (
        output id_valid, id_raddr1, id_raddr2, id_re1, id_re2,
        output ds_fire, ds_dest, ds_gr_we, ds_is_load,
        output es_fire, ms_fire, ws_fire,
        input  block_id, fwd_sel1, fwd_sel2, sb_busy, stall_cnt, sb_overflow
    );

    modport slave (
        input  id_valid, id_raddr1, id_raddr2, id_re1, id_re2,
        input  ds_fire, ds_dest, ds_gr_we, ds_is_load,
        input  es_fire, ms_fire, ws_fire,
        output block_id, fwd_sel1, fwd_sel2, sb_busy, stall_cnt, sb_overflow
    );

endinterface
`default_nettype wire

// File: rtl/hazard_tag_slot.sv
`default_nettype none
// ============================================================================
// Module      : hazard_tag_slot
// Description : One shadow tag register with load / clear-valid / hold.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_tag_slot
    import hazard_scoreboard_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_load,
    input  wire tag_t i_tag,
    input  wire logic i_clear,
    output tag_t      o_tag
);

    tag_t r_tag;

    // Load takes priority over clear: a slot refilled the same cycle it drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= '0;
        end else if (i_load) begin
            r_tag <= i_tag;
        end else if (i_clear) begin
            r_tag.v <= 1'b0;
        end
    end

    assign o_tag = r_tag;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks in-flight GPR writers across EXE/MEM/WB, produces
//               forward selects, load-use stall and per-GPR busy bits.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_scoreboard_if.slave sb
);

    tag_t        w_ds_tag;
    tag_t        w_tag_e;
    tag_t        w_tag_m;
    tag_t        w_tag_w;
    logic        w_block;
    logic [31:0] w_busy;
    logic [31:0] w_err;
    logic [31:0] r_stall_cnt;
    logic        r_overflow;
    logic        w_unused_w_ld;

    always_comb begin
        w_ds_tag      = '0;
        w_ds_tag.v    = 1'b1;
        w_ds_tag.we   = sb.ds_gr_we;
        w_ds_tag.dest = sb.ds_dest;
        w_ds_tag.ld   = sb.ds_is_load;
    end

    hazard_tag_slot u_slot_e (
        .clk     (clk),
        .reset   (reset),
        .i_load  (sb.ds_fire),
        .i_tag   (w_ds_tag),
        .i_clear (sb.es_fire),
        .o_tag   (w_tag_e)
    );

    hazard_tag_slot u_slot_m (
        .clk     (clk),
        .reset   (reset),
        .i_load  (sb.es_fire),
        .i_tag   (w_tag_e),
        .i_clear (sb.ms_fire),
        .o_tag   (w_tag_m)
    );

    hazard_tag_slot u_slot_w (
        .clk     (clk),
        .reset   (reset),
        .i_load  (sb.ms_fire),
        .i_tag   (w_tag_m),
        .i_clear (sb.ws_fire),
        .o_tag   (w_tag_w)
    );

    assign w_unused_w_ld = w_tag_w.ld;

    // Only a load still in EXE cannot forward in time; MEM/WB loads forward.
    assign w_block = sb.id_valid &
                     ((tag_hit(w_tag_e, sb.id_re1, sb.id_raddr1) & w_tag_e.ld) |
                      (tag_hit(w_tag_e, sb.id_re2, sb.id_raddr2) & w_tag_e.ld));

    assign sb.block_id = w_block;
    assign sb.fwd_sel1 = fwd_select(sb.id_re1, sb.id_raddr1, w_tag_e, w_tag_m, w_tag_w);
    assign sb.fwd_sel2 = fwd_select(sb.id_re2, sb.id_raddr2, w_tag_e, w_tag_m, w_tag_w);

    assign w_busy[0] = 1'b0;
    assign w_err[0]  = 1'b0;

    for (genvar r = 1; r < C_NUM_GPR; r++) begin : g_gpr
        logic       w_inc;
        logic       w_dec;
        logic [1:0] r_cnt;

        assign w_inc = sb.ds_fire & sb.ds_gr_we & (sb.ds_dest == 5'(r));
        assign w_dec = sb.ws_fire & w_tag_w.v & w_tag_w.we & (w_tag_w.dest == 5'(r));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec && r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (w_dec && !w_inc && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end

        assign w_err[r]  = (w_inc & ~w_dec & (r_cnt == C_CNT_MAX)) |
                           (w_dec & ~w_inc & (r_cnt == 2'd0));
        assign w_busy[r] = |r_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_overflow <= r_overflow | (|w_err);
            if (w_block && r_stall_cnt != 32'hFFFF_FFFF) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign sb.sb_busy     = w_busy;
    assign sb.stall_cnt   = r_stall_cnt;
    assign sb.sb_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_scoreboard_if sb_if ();

    hazard_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.id_valid   = 1'b0;
        sb_if.id_raddr1  = 5'd0;
        sb_if.id_raddr2  = 5'd0;
        sb_if.id_re1     = 1'b0;
        sb_if.id_re2     = 1'b0;
        sb_if.ds_fire    = 1'b0;
        sb_if.ds_dest    = 5'd0;
        sb_if.ds_gr_we   = 1'b0;
        sb_if.ds_is_load = 1'b0;
        sb_if.es_fire    = 1'b0;
        sb_if.ms_fire    = 1'b0;
        sb_if.ws_fire    = 1'b0;
    endtask

    task automatic issue(input logic [4:0] dest, input logic we, input logic ld);
        sb_if.ds_fire    = 1'b1;
        sb_if.ds_dest    = dest;
        sb_if.ds_gr_we   = we;
        sb_if.ds_is_load = ld;
    endtask

    task automatic fires(input logic es, input logic ms, input logic ws);
        sb_if.es_fire = es;
        sb_if.ms_fire = ms;
        sb_if.ws_fire = ws;
    endtask

    task automatic read_id(input logic re1, input logic [4:0] a1, input logic re2, input logic [4:0] a2);
        sb_if.id_valid  = 1'b1;
        sb_if.id_re1    = re1;
        sb_if.id_raddr1 = a1;
        sb_if.id_re2    = re2;
        sb_if.id_raddr2 = a2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();

        // Reset must override a concurrent write issue.
        reset = 1'b1;
        issue(5'd5, 1'b1, 1'b1);
        fires(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("rst_busy", sb_if.sb_busy, 32'h0);
        check("rst_block", {31'b0, sb_if.block_id}, 32'd0);
        check("rst_stall", sb_if.stall_cnt, 32'd0);
        check("rst_ovf", {31'b0, sb_if.sb_overflow}, 32'd0);
        read_id(1'b1, 5'd5, 1'b1, 5'd5);
        #1;
        check("rst_fwd1", {30'b0, sb_if.fwd_sel1}, 32'd0);
        check("rst_fwd2", {30'b0, sb_if.fwd_sel2}, 32'd0);
        idle();

        // Load-use on r5.
        issue(5'd5, 1'b1, 1'b1);
        tick();
        idle();
        #1;
        check("ld_busy", sb_if.sb_busy, 32'h0000_0020);
        read_id(1'b1, 5'd5, 1'b0, 5'd5);
        sb_if.id_valid = 1'b0;
        #1;
        check("ld_block_novalid", {31'b0, sb_if.block_id}, 32'd0);
        sb_if.id_valid = 1'b1;
        #1;
        check("ld_block", {31'b0, sb_if.block_id}, 32'd1);
        check("ld_fwd1_exe", {30'b0, sb_if.fwd_sel1}, 32'd1);
        check("ld_fwd2_nore", {30'b0, sb_if.fwd_sel2}, 32'd0);
        fires(1'b1, 1'b0, 1'b0);
        tick();
        fires(1'b0, 1'b0, 1'b0);
        #1;
        check("ld_stall_cnt", sb_if.stall_cnt, 32'd1);
        check("ld_block_mem", {31'b0, sb_if.block_id}, 32'd0);
        check("ld_fwd1_mem", {30'b0, sb_if.fwd_sel1}, 32'd2);
        fires(1'b0, 1'b1, 1'b0);
        tick();
        fires(1'b0, 1'b0, 1'b0);
        #1;
        check("ld_fwd1_wb", {30'b0, sb_if.fwd_sel1}, 32'd3);
        check("ld_busy_wb", sb_if.sb_busy, 32'h0000_0020);
        fires(1'b0, 1'b0, 1'b1);
        tick();
        fires(1'b0, 1'b0, 1'b0);
        #1;
        check("ld_busy_ret", sb_if.sb_busy, 32'h0);
        check("ld_fwd1_rf", {30'b0, sb_if.fwd_sel1}, 32'd0);
        idle();

        // Two writers of r7: youngest in EXE wins.
        issue(5'd7, 1'b1, 1'b0);
        tick();
        issue(5'd7, 1'b1, 1'b0);
        fires(1'b1, 1'b0, 1'b0);
        tick();
        idle();
        read_id(1'b1, 5'd7, 1'b1, 5'd7);
        #1;
        check("r7_fwd2_exe", {30'b0, sb_if.fwd_sel2}, 32'd1);
        check("r7_fwd1_exe", {30'b0, sb_if.fwd_sel1}, 32'd1);
        check("r7_block", {31'b0, sb_if.block_id}, 32'd0);
        check("r7_busy", sb_if.sb_busy, 32'h0000_0080);
        fires(1'b1, 1'b1, 1'b0);
        tick();
        fires(1'b0, 1'b0, 1'b0);
        #1;
        check("r7_fwd2_mem", {30'b0, sb_if.fwd_sel2}, 32'd2);
        fires(1'b0, 1'b1, 1'b1);
        tick();
        fires(1'b0, 1'b0, 1'b0);
        #1;
        check("r7_fwd2_wb", {30'b0, sb_if.fwd_sel2}, 32'd3);
        check("r7_busy_one", sb_if.sb_busy, 32'h0000_0080);
        fires(1'b0, 1'b0, 1'b1);
        tick();
        fires(1'b0, 1'b0, 1'b0);
        #1;
        check("r7_busy_ret", sb_if.sb_busy, 32'h0);
        idle();

        // Writes to r0 are never tracked, even as a load in EXE.
        issue(5'd0, 1'b1, 1'b1);
        tick();
        idle();
        read_id(1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        check("r0_busy", sb_if.sb_busy, 32'h0);
        check("r0_fwd1", {30'b0, sb_if.fwd_sel1}, 32'd0);
        check("r0_block", {31'b0, sb_if.block_id}, 32'd0);
        idle();
        fires(1'b1, 1'b0, 1'b0);
        tick();
        fires(1'b0, 1'b1, 1'b0);
        tick();
        fires(1'b0, 1'b0, 1'b1);
        tick();
        fires(1'b0, 1'b0, 1'b0);
        #1;
        check("r0_busy_ret", sb_if.sb_busy, 32'h0);
        check("r0_ovf", {31'b0, sb_if.sb_overflow}, 32'd0);

        // Full pipeline shift with r9 retiring while r9 issues.
        issue(5'd9, 1'b1, 1'b0);
        tick();
        issue(5'd10, 1'b1, 1'b0);
        fires(1'b1, 1'b0, 1'b0);
        tick();
        issue(5'd11, 1'b1, 1'b0);
        fires(1'b1, 1'b1, 1'b0);
        tick();
        issue(5'd9, 1'b1, 1'b0);
        fires(1'b1, 1'b1, 1'b1);
        tick();
        idle();
        read_id(1'b1, 5'd10, 1'b1, 5'd11);
        #1;
        check("shift_busy", sb_if.sb_busy, 32'h0000_0E00);
        check("shift_fwd1_r10", {30'b0, sb_if.fwd_sel1}, 32'd3);
        check("shift_fwd2_r11", {30'b0, sb_if.fwd_sel2}, 32'd2);
        read_id(1'b1, 5'd9, 1'b0, 5'd0);
        #1;
        check("shift_fwd1_r9", {30'b0, sb_if.fwd_sel1}, 32'd1);
        idle();
        fires(1'b1, 1'b1, 1'b1);
        tick();
        #1;
        check("shift_busy_d1", sb_if.sb_busy, 32'h0000_0A00);
        fires(1'b0, 1'b1, 1'b1);
        tick();
        fires(1'b0, 1'b0, 1'b1);
        tick();
        fires(1'b0, 1'b0, 1'b0);
        #1;
        check("shift_busy_drain", sb_if.sb_busy, 32'h0);
        check("shift_ovf", {31'b0, sb_if.sb_overflow}, 32'd0);

        // Counter saturation on r3 and sticky overflow.
        issue(5'd3, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        #1;
        check("sat_ovf_at3", {31'b0, sb_if.sb_overflow}, 32'd0);
        tick();
        idle();
        tick();
        check("sat_ovf", {31'b0, sb_if.sb_overflow}, 32'd1);
        check("sat_busy", sb_if.sb_busy, 32'h0000_0008);
        check("sat_stall_keep", sb_if.stall_cnt, 32'd1);

        // Mid-operation reset with r3 still in EXE.
        reset = 1'b1;
        fires(1'b0, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        idle();
        read_id(1'b1, 5'd3, 1'b1, 5'd3);
        #1;
        check("mrst_busy", sb_if.sb_busy, 32'h0);
        check("mrst_ovf", {31'b0, sb_if.sb_overflow}, 32'd0);
        check("mrst_stall", sb_if.stall_cnt, 32'd0);
        check("mrst_fwd1", {30'b0, sb_if.fwd_sel1}, 32'd0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
